// File: rtl/lstm_cell_update.sv
// LSTM cell-state / hidden-output update engine driven by the gate memory sequencer strobes.
// Computes c_new = sat(f*c_pre + i*g) and h_new = o * pwl_tanh(c_new), one element per slot.
module lstm_cell_update #(
  parameter int WL      = 16,
  parameter int FL      = 12,
  parameter int N_CELLS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_net,
  input  logic                 f_done,
  input  logic                 i_done,
  input  logic                 c_done,
  input  logic signed [WL-1:0] mem_net1,
  input  logic signed [WL-1:0] mem_net2,
  input  logic signed [WL-1:0] c_pre,
  output logic signed [WL-1:0] c_new,
  output logic signed [WL-1:0] h_new,
  output logic                 c_valid,
  output logic                 h_valid,
  output logic [7:0]           cell_count,
  output logic                 all_done,
  output logic                 protocol_err
);

  typedef enum logic [2:0] {IDLE, WAIT_I, SUM, TANH, WAIT_O} state_t;

  localparam logic [WL-1:0] HALF  = WL'(1) << (FL - 1);
  localparam logic [WL-1:0] QUART = WL'(1) << (FL - 2);
  localparam logic [WL-1:0] ONE   = WL'(1) << FL;
  localparam logic [WL-1:0] KNEE  = HALF + ONE;

  state_t state, state_next;
  logic signed [WL-1:0] fc, ig, th;
  logic take_f, take_i, take_o, strobe_err, multi;
  logic [1:0] n_str;

  function automatic logic signed [WL-1:0] sat_wide(input logic signed [2*WL:0] v);
    logic signed [2*WL:0] hi, lo;
    hi = {{(WL+2){1'b0}}, {(WL-1){1'b1}}};
    lo = {{(WL+2){1'b1}}, {(WL-1){1'b0}}};
    if (v > hi)      return hi[WL-1:0];
    else if (v < lo) return lo[WL-1:0];
    else             return v[WL-1:0];
  endfunction

  // Round-half-up fixed-point multiply with saturation.
  function automatic logic signed [WL-1:0] mul(input logic signed [WL-1:0] a,
                                                input logic signed [WL-1:0] b);
    logic signed [2*WL:0] ae, be, p, rnd;
    ae  = {{(WL+1){a[WL-1]}}, a};
    be  = {{(WL+1){b[WL-1]}}, b};
    rnd = '0;
    rnd[FL-1] = 1'b1;
    p = ae * be + rnd;
    return sat_wide(p >>> FL);
  endfunction

  function automatic logic signed [WL-1:0] sat_add(input logic signed [WL-1:0] a,
                                                    input logic signed [WL-1:0] b);
    logic signed [WL:0] s;
    s = {a[WL-1], a} + {b[WL-1], b};
    return sat_wide({{WL{s[WL]}}, s});
  endfunction

  // Three-segment odd tanh: identity, slope 1/2 with 0.25 offset, then clamp at 1.0.
  function automatic logic signed [WL-1:0] pwl_tanh(input logic signed [WL-1:0] x);
    logic [WL-1:0] a, r;
    if (x == {1'b1, {(WL-1){1'b0}}}) a = {1'b0, {(WL-1){1'b1}}};
    else if (x[WL-1])                a = WL'(-x);
    else                             a = WL'(x);
    if (a < HALF)      r = a;
    else if (a < KNEE) r = (a >> 1) + QUART;
    else               r = ONE;
    return x[WL-1] ? -$signed(r) : $signed(r);
  endfunction

  always_comb begin
    n_str      = {1'b0, f_done} + {1'b0, i_done} + {1'b0, c_done};
    multi      = n_str > 2'd1;
    state_next = state;
    take_f     = 1'b0;
    take_i     = 1'b0;
    take_o     = 1'b0;
    strobe_err = 1'b0;
    case (state)
      IDLE: begin
        if (multi || i_done || c_done) strobe_err = 1'b1;
        else if (f_done) begin take_f = 1'b1; state_next = WAIT_I; end
      end
      WAIT_I: begin
        if (multi || f_done || c_done) strobe_err = 1'b1;
        else if (i_done) begin take_i = 1'b1; state_next = SUM; end
      end
      SUM: begin
        strobe_err = n_str != 2'd0;
        state_next = TANH;
      end
      TANH: begin
        strobe_err = n_str != 2'd0;
        state_next = WAIT_O;
      end
      WAIT_O: begin
        if (multi || f_done || i_done) strobe_err = 1'b1;
        else if (c_done) begin take_o = 1'b1; state_next = IDLE; end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         state <= IDLE;
    else if (start_net) state <= IDLE;
    else                state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc <= '0; ig <= '0; th <= '0;
      c_new <= '0; h_new <= '0;
      c_valid <= 1'b0; h_valid <= 1'b0; all_done <= 1'b0;
      cell_count <= '0; protocol_err <= 1'b0;
    end else begin
      c_valid  <= 1'b0;
      h_valid  <= 1'b0;
      all_done <= 1'b0;
      if (start_net) begin
        cell_count   <= '0;
        protocol_err <= 1'b0;
      end else begin
        if (strobe_err) protocol_err <= 1'b1;
        if (cell_count == 8'(N_CELLS)) cell_count <= '0;
        if (take_f) fc <= mul(mem_net1, c_pre);
        if (take_i) ig <= mul(mem_net1, mem_net2);
        if (state == SUM) begin
          c_new   <= sat_add(fc, ig);
          c_valid <= 1'b1;
        end
        if (state == TANH) th <= pwl_tanh(c_new);
        if (take_o) begin
          h_new      <= mul(mem_net1, th);
          h_valid    <= 1'b1;
          cell_count <= cell_count + 8'd1;
          all_done   <= (cell_count + 8'd1) == 8'(N_CELLS);
        end
      end
    end
  end

endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed and randomized bench for lstm_cell_update against an integer reference model.
module tb_lstm_cell_update;

  logic clk = 1'b0;
  logic rst_n, start_net, f_done, i_done, c_done;
  logic signed [15:0] mem_net1, mem_net2, c_pre;
  logic signed [15:0] c_new, h_new;
  logic c_valid, h_valid, all_done, protocol_err;
  logic [7:0] cell_count;

  int errors = 0;
  int checks = 0;
  int mcount = 0;

  lstm_cell_update #(.WL(16), .FL(12), .N_CELLS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start_net(start_net),
    .f_done(f_done), .i_done(i_done), .c_done(c_done),
    .mem_net1(mem_net1), .mem_net2(mem_net2), .c_pre(c_pre),
    .c_new(c_new), .h_new(h_new), .c_valid(c_valid), .h_valid(h_valid),
    .cell_count(cell_count), .all_done(all_done), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic f, input logic i, input logic c,
                       input longint n1, input longint n2, input longint cp);
    f_done = f; i_done = i; c_done = c;
    mem_net1 = 16'(n1); mem_net2 = 16'(n2); c_pre = 16'(cp);
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint mul_ref(input longint a, input longint b);
    return sat16((a * b + 2048) >>> 12);
  endfunction

  function automatic longint tanh_ref(input longint c);
    longint a, r;
    a = (c < 0) ? -c : c;
    if (a > 32767) a = 32767;
    if (a < 2048)      r = a;
    else if (a < 6144) r = a / 2 + 1024;
    else               r = 4096;
    return (c < 0) ? -r : r;
  endfunction

  function automatic longint rnd_val(input bit wide);
    logic signed [15:0] t;
    t = 16'($urandom());
    if (wide) return t;
    return longint'($urandom_range(12288)) - 6144;
  endfunction

  // One 6-cycle slot: f at T, i at T+1, c_done at T+5; ends in cycle T+6.
  task automatic run_element(input string tag, input longint f, input longint cp, input longint i,
                             input longint g, input longint o);
    longint ec, eh;
    ec = sat16(mul_ref(f, cp) + mul_ref(i, g));
    eh = mul_ref(o, tanh_ref(ec));
    drive(1, 0, 0, f, 0, cp);  tick();
    drive(0, 1, 0, i, g, 0);   tick();
    drive(0, 0, 0, 0, 0, 0);   tick();
    check({tag, ".c_valid"}, c_valid, 1);
    check({tag, ".c_new"}, c_new, ec);
    tick();
    check({tag, ".c_valid_pulse"}, c_valid, 0);
    tick();
    drive(0, 0, 1, o, 0, 0);   tick();
    drive(0, 0, 0, 0, 0, 0);
    mcount++;
    check({tag, ".h_valid"}, h_valid, 1);
    check({tag, ".h_new"}, h_new, eh);
    check({tag, ".c_new_held"}, c_new, ec);
    check({tag, ".cell_count"}, cell_count, mcount);
    check({tag, ".all_done"}, all_done, (mcount == 64) ? 1 : 0);
    if (mcount == 64) mcount = 0;
  endtask

  task automatic restart();
    start_net = 1'b1; tick();
    start_net = 1'b0;
    mcount = 0;
    check("start.cell_count", cell_count, 0);
    check("start.protocol_err", protocol_err, 0);
  endtask

  initial begin
    rst_n = 1'b0; start_net = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst.c_new", c_new, 0);
    check("rst.h_new", h_new, 0);
    check("rst.c_valid", c_valid, 0);
    check("rst.h_valid", h_valid, 0);
    check("rst.cell_count", cell_count, 0);
    check("rst.all_done", all_done, 0);
    check("rst.protocol_err", protocol_err, 0);
    rst_n = 1'b1; tick();

    run_element("basic", 2048, 4096, 2048, 2048, 4096);
    check("basic.literal_h", h_new, 2560);
    run_element("sat_pos", 28672, 28672, 0, 0, -4096);
    check("sat_pos.literal_c", c_new, 32767);
    run_element("tanh_small", 4096, 1024, 0, 0, 4096);
    run_element("tanh_mid_neg", 4096, -4096, 0, 0, 4096);
    check("tanh_mid_neg.literal_h", h_new, -3072);
    run_element("tanh_min", -28672, 28672, 0, 0, 4096);
    check("tanh_min.literal_h", h_new, -4096);
    restart();

    for (int k = 0; k < 64; k++)
      run_element($sformatf("rand%0d", k), rnd_val(k[0]), rnd_val(k[0]), rnd_val(k[1]),
                  rnd_val(k[1]), rnd_val(k[2]));
    tick();
    check("wrap.cell_count", cell_count, 0);
    check("wrap.all_done", all_done, 0);
    check("wrap.protocol_err", protocol_err, 0);

    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    check("err_idle.protocol_err", protocol_err, 1);
    run_element("after_err_idle", 3000, -2000, 1500, 4000, -3000);
    check("err_sticky", protocol_err, 1);
    restart();

    drive(1, 0, 0, 4096, 0, 2048); tick();
    drive(0, 0, 1, 0, 0, 0);       tick();
    drive(0, 1, 0, 4096, 4096, 0); tick();
    check("err_wait_i.protocol_err", protocol_err, 1);
    drive(0, 0, 0, 0, 0, 0);       tick();
    check("err_wait_i.c_new", c_new, 6144);
    repeat (2) tick();
    drive(0, 0, 1, 4096, 0, 0);    tick();
    drive(0, 0, 0, 0, 0, 0);
    check("err_wait_i.h_new", h_new, 4096);
    check("err_wait_i.cell_count", cell_count, 1);
    restart();

    drive(1, 1, 0, 4096, 4096, 4096); tick();
    drive(0, 0, 0, 0, 0, 0);          tick();
    check("err_multi.protocol_err", protocol_err, 1);
    run_element("after_multi", -1000, 5000, 2500, -2500, 2000);
    check("after_multi.err_sticky", protocol_err, 1);
    restart();

    drive(1, 0, 0, 4096, 0, 8192); tick();
    drive(0, 1, 0, 4096, 4096, 0); tick();
    drive(0, 0, 0, 0, 0, 0);       repeat (2) tick();
    rst_n = 1'b0; #1;
    check("async_rst.c_new", c_new, 0);
    check("async_rst.h_new", h_new, 0);
    check("async_rst.c_valid", c_valid, 0);
    check("async_rst.cell_count", cell_count, 0);
    tick();
    rst_n = 1'b1; mcount = 0; tick();
    run_element("post_rst", 2048, 4096, 2048, 2048, 4096);
    check("post_rst.protocol_err", protocol_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
